// File: rtl/bp_update_arbiter.sv
// Merges two EX branch-resolution ports onto the single PD_Stage predictor update/restore bus.
// Mispredicts preempt and squash younger queued training updates; training updates drain in order.
module bp_update_arbiter #(
  parameter int XLEN        = 32,
  parameter int GHR_SIZE    = 9,
  parameter int PHT_ADDRESS = 9,
  parameter int RAS_ADDRESS = 3,
  parameter int ROB_TAG     = 5,
  parameter int QDEPTH      = 4
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [ROB_TAG-1:0]     rob_head,

  input  logic                   req0_valid,
  input  logic [ROB_TAG-1:0]     req0_tag,
  input  logic                   req0_mispredict,
  input  logic                   req0_taken,
  input  logic                   req0_is_branch,
  input  logic                   req0_is_ret,
  input  logic                   req0_is_call,
  input  logic [XLEN-1:0]        req0_pc,
  input  logic [XLEN-1:0]        req0_target,
  input  logic [XLEN-1:0]        req0_ret_addr,
  input  logic [GHR_SIZE-1:0]    req0_ghr_snap,
  input  logic [PHT_ADDRESS-1:0] req0_pht_index,
  input  logic [RAS_ADDRESS-1:0] req0_sp_snap,
  input  logic [2*XLEN-1:0]      req0_ras_snap,

  input  logic                   req1_valid,
  input  logic [ROB_TAG-1:0]     req1_tag,
  input  logic                   req1_mispredict,
  input  logic                   req1_taken,
  input  logic                   req1_is_branch,
  input  logic                   req1_is_ret,
  input  logic                   req1_is_call,
  input  logic [XLEN-1:0]        req1_pc,
  input  logic [XLEN-1:0]        req1_target,
  input  logic [XLEN-1:0]        req1_ret_addr,
  input  logic [GHR_SIZE-1:0]    req1_ghr_snap,
  input  logic [PHT_ADDRESS-1:0] req1_pht_index,
  input  logic [RAS_ADDRESS-1:0] req1_sp_snap,
  input  logic [2*XLEN-1:0]      req1_ras_snap,

  output logic                   req_ready,
  output logic                   actual_taken,
  output logic                   mispredict,
  output logic                   restore_ghr,
  output logic                   restore_ras,
  output logic                   update_pht,
  output logic                   update_btb,
  output logic                   update_ras,
  output logic                   ex_is_ret,
  output logic                   ex_is_branch,
  output logic [XLEN-1:0]        actual_target_address,
  output logic [XLEN-1:0]        actual_return_address,
  output logic [XLEN-1:0]        ex_pc,
  output logic [GHR_SIZE-1:0]    ghr_snap,
  output logic [PHT_ADDRESS-1:0] rb_pht_index,
  output logic [RAS_ADDRESS-1:0] rb_sp_snap,
  output logic [2*XLEN-1:0]      rb_ras_snap,
  output logic [1:0]             dbg_state
);

  localparam int IW = $clog2(QDEPTH);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAIN   = 2'd1,
    S_RECOVER = 2'd2,
    S_BUBBLE  = 2'd3
  } state_t;

  typedef struct packed {
    logic                   taken;
    logic                   is_branch;
    logic                   is_ret;
    logic [XLEN-1:0]        pc;
    logic [XLEN-1:0]        target;
    logic [XLEN-1:0]        ret_addr;
    logic [GHR_SIZE-1:0]    ghr;
    logic [PHT_ADDRESS-1:0] pht;
    logic [RAS_ADDRESS-1:0] sp;
    logic [2*XLEN-1:0]      ras;
  } bus_t;

  typedef struct packed {
    logic [ROB_TAG-1:0] tag;
    logic               is_call;
    bus_t               data;
  } entry_t;

  function automatic logic [ROB_TAG-1:0] age_of(input logic [ROB_TAG-1:0] tag,
                                                input logic [ROB_TAG-1:0] head);
    return tag - head;
  endfunction

  state_t          state_q;
  entry_t          q_q [QDEPTH];
  entry_t          q_d [QDEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic            ready_q, ready_d;
  bus_t            bus_q;
  logic            mp_q, restore_q, upd_pht_q, upd_btb_q, upd_ras_q;

  entry_t          in0, in1, mp_ent, head;
  logic            mp0, mp1, mp_any, mp_sel1, tr0, tr1, issue;
  logic [ROB_TAG-1:0] age0, age1, mp_age;

  always_comb begin
    in0.tag            = req0_tag;
    in0.is_call        = req0_is_call;
    in0.data.taken     = req0_taken;
    in0.data.is_branch = req0_is_branch;
    in0.data.is_ret    = req0_is_ret;
    in0.data.pc        = req0_pc;
    in0.data.target    = req0_target;
    in0.data.ret_addr  = req0_ret_addr;
    in0.data.ghr       = req0_ghr_snap;
    in0.data.pht       = req0_pht_index;
    in0.data.sp        = req0_sp_snap;
    in0.data.ras       = req0_ras_snap;
    in1.tag            = req1_tag;
    in1.is_call        = req1_is_call;
    in1.data.taken     = req1_taken;
    in1.data.is_branch = req1_is_branch;
    in1.data.is_ret    = req1_is_ret;
    in1.data.pc        = req1_pc;
    in1.data.target    = req1_target;
    in1.data.ret_addr  = req1_ret_addr;
    in1.data.ghr       = req1_ghr_snap;
    in1.data.pht       = req1_pht_index;
    in1.data.sp        = req1_sp_snap;
    in1.data.ras       = req1_ras_snap;
  end

  // Handshake: a port transfers when reqN_valid is high at a posedge. Training transfers are only
  // honoured while req_ready (registered) is high; mispredicts are always taken since they need no slot.
  always_comb begin
    age0    = age_of(req0_tag, rob_head);
    age1    = age_of(req1_tag, rob_head);
    mp0     = req0_valid & req0_mispredict;
    mp1     = req1_valid & req1_mispredict;
    mp_any  = mp0 | mp1;
    mp_sel1 = mp1 & (~mp0 | (age1 < age0));
    mp_ent  = mp_sel1 ? in1 : in0;
    mp_age  = mp_sel1 ? age1 : age0;
    tr0     = req0_valid & ~req0_mispredict & ready_q & (~mp_any | (age0 < mp_age));
    tr1     = req1_valid & ~req1_mispredict & ready_q & (~mp_any | (age1 < mp_age));
  end

  // Queue is kept compacted at index 0 so a squash can remove entries from anywhere.
  always_comb begin
    logic [CW-1:0] k;
    q_d     = q_q;
    count_d = count_q;
    issue   = 1'b0;
    head    = '0;
    k       = '0;
    if (mp_any) begin
      for (int i = 0; i < QDEPTH; i++) begin
        if ((CW'(i) < count_q) && (age_of(q_q[i].tag, rob_head) <= mp_age)) begin
          q_d[k[IW-1:0]] = q_q[i];
          k = k + 1'b1;
        end
      end
      count_d = k;
    end
    if (tr0 && (count_d < QDEPTH_C)) begin
      q_d[count_d[IW-1:0]] = in0;
      count_d = count_d + 1'b1;
    end
    if (tr1 && (count_d < QDEPTH_C)) begin
      q_d[count_d[IW-1:0]] = in1;
      count_d = count_d + 1'b1;
    end
    // Popping after the enqueue lets a request into an empty queue issue on the very next edge.
    if (!mp_any && (state_q != S_RECOVER) && (count_d != '0)) begin
      issue = 1'b1;
      head  = q_d[0];
      for (int i = 0; i < QDEPTH - 1; i++) begin
        q_d[i] = q_d[i+1];
      end
      count_d = count_d - 1'b1;
    end
    ready_d = (count_d <= (QDEPTH_C - CW'(2)));
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      ready_q   <= 1'b1;
      bus_q     <= '0;
      mp_q      <= 1'b0;
      restore_q <= 1'b0;
      upd_pht_q <= 1'b0;
      upd_btb_q <= 1'b0;
      upd_ras_q <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) q_q[i] <= '0;
    end else begin
      q_q     <= q_d;
      count_q <= count_d;
      ready_q <= ready_d;
      if (mp_any) begin
        state_q   <= S_RECOVER;
        bus_q     <= mp_ent.data;
        mp_q      <= 1'b1;
        restore_q <= 1'b1;
        upd_pht_q <= mp_ent.data.is_branch;
        upd_btb_q <= 1'b1;
        upd_ras_q <= mp_ent.is_call | mp_ent.data.is_ret;
      end else if (issue) begin
        state_q   <= S_DRAIN;
        bus_q     <= head.data;
        mp_q      <= 1'b0;
        restore_q <= 1'b0;
        upd_pht_q <= head.data.is_branch;
        upd_btb_q <= head.data.taken | ~head.data.is_branch;
        upd_ras_q <= head.is_call | head.data.is_ret;
      end else begin
        mp_q      <= 1'b0;
        restore_q <= 1'b0;
        upd_pht_q <= 1'b0;
        upd_btb_q <= 1'b0;
        upd_ras_q <= 1'b0;
        if (state_q == S_RECOVER) begin
          state_q <= S_BUBBLE;
          bus_q   <= '0;
        end else begin
          state_q <= S_IDLE;
        end
      end
    end
  end

  assign req_ready             = ready_q;
  assign mispredict            = mp_q;
  assign restore_ghr           = restore_q;
  assign restore_ras           = restore_q;
  assign update_pht            = upd_pht_q;
  assign update_btb            = upd_btb_q;
  assign update_ras            = upd_ras_q;
  assign actual_taken          = bus_q.taken;
  assign ex_is_ret             = bus_q.is_ret;
  assign ex_is_branch          = bus_q.is_branch;
  assign actual_target_address = bus_q.target;
  assign actual_return_address = bus_q.ret_addr;
  assign ex_pc                 = bus_q.pc;
  assign ghr_snap              = bus_q.ghr;
  assign rb_pht_index          = bus_q.pht;
  assign rb_sp_snap            = bus_q.sp;
  assign rb_ras_snap           = bus_q.ras;
  assign dbg_state             = state_q;

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Directed bench for bp_update_arbiter: table of single training requests, then hand-built
// sequences for pairing, back-pressure, mispredict squash, port arbitration, restart and reset.
module tb_bp_update_arbiter;

  typedef struct packed {
    logic        valid;
    logic [4:0]  tag;
    logic        mp;
    logic        taken;
    logic        br;
    logic        ret;
    logic        call;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] ra;
    logic [8:0]  ghr;
    logic [8:0]  pht;
    logic [2:0]  sp;
    logic [63:0] ras;
  } req_t;

  typedef struct packed {
    logic        port;
    logic        taken;
    logic        br;
    logic        ret;
    logic        call;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] ra;
    logic [5:0]  exp_str;
  } vec_t;

  logic        CLK = 1'b0;
  logic        reset;
  logic [4:0]  rob_head;
  req_t        r0, r1;

  logic        req_ready, actual_taken, mispredict, restore_ghr, restore_ras;
  logic        update_pht, update_btb, update_ras, ex_is_ret, ex_is_branch;
  logic [31:0] actual_target_address, actual_return_address, ex_pc;
  logic [8:0]  ghr_snap, rb_pht_index;
  logic [2:0]  rb_sp_snap;
  logic [63:0] rb_ras_snap;
  logic [1:0]  dbg_state;
  logic [5:0]  strobes;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  vec_t vecs[6];

  always #5 CLK = ~CLK;

  assign strobes = {mispredict, restore_ghr, restore_ras, update_pht, update_btb, update_ras};

  bp_update_arbiter dut (
    .CLK(CLK), .reset(reset), .rob_head(rob_head),
    .req0_valid(r0.valid), .req0_tag(r0.tag), .req0_mispredict(r0.mp), .req0_taken(r0.taken),
    .req0_is_branch(r0.br), .req0_is_ret(r0.ret), .req0_is_call(r0.call), .req0_pc(r0.pc),
    .req0_target(r0.tgt), .req0_ret_addr(r0.ra), .req0_ghr_snap(r0.ghr),
    .req0_pht_index(r0.pht), .req0_sp_snap(r0.sp), .req0_ras_snap(r0.ras),
    .req1_valid(r1.valid), .req1_tag(r1.tag), .req1_mispredict(r1.mp), .req1_taken(r1.taken),
    .req1_is_branch(r1.br), .req1_is_ret(r1.ret), .req1_is_call(r1.call), .req1_pc(r1.pc),
    .req1_target(r1.tgt), .req1_ret_addr(r1.ra), .req1_ghr_snap(r1.ghr),
    .req1_pht_index(r1.pht), .req1_sp_snap(r1.sp), .req1_ras_snap(r1.ras),
    .req_ready(req_ready), .actual_taken(actual_taken), .mispredict(mispredict),
    .restore_ghr(restore_ghr), .restore_ras(restore_ras), .update_pht(update_pht),
    .update_btb(update_btb), .update_ras(update_ras), .ex_is_ret(ex_is_ret),
    .ex_is_branch(ex_is_branch), .actual_target_address(actual_target_address),
    .actual_return_address(actual_return_address), .ex_pc(ex_pc), .ghr_snap(ghr_snap),
    .rb_pht_index(rb_pht_index), .rb_sp_snap(rb_sp_snap), .rb_ras_snap(rb_ras_snap),
    .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Inputs change 1 time unit after a posedge; outputs are sampled at the same point.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic req_t mk_train(input logic [4:0] tag, input logic [31:0] pc);
    req_t t = '0;
    t.valid = 1'b1; t.tag = tag; t.taken = 1'b1; t.pc = pc;
    t.tgt = pc + 32'h40; t.ra = pc + 32'h4;
    return t;
  endfunction

  function automatic req_t mk_mp(input logic [4:0] tag, input logic [31:0] pc, input logic br,
                                 input logic call, input logic ret, input logic [8:0] ghr,
                                 input logic [2:0] sp);
    req_t t = '0;
    t.valid = 1'b1; t.mp = 1'b1; t.tag = tag; t.taken = 1'b1; t.br = br; t.call = call;
    t.ret = ret; t.pc = pc; t.tgt = pc + 32'h100; t.ra = pc + 32'h4; t.ghr = ghr;
    t.pht = 9'h033; t.sp = sp; t.ras = {pc, ~pc};
    return t;
  endfunction

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4,   32'h4,   32'h44444444, 6'b000010};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h200, 32'h104,      6'b000110};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h104, 32'h108, 32'h108,      6'b000100};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'h800, 32'h204,      6'b000011};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h804, 32'h204, 32'h808,      6'b000011};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h340, 32'h304,      6'b000100};

    // T1: reset
    reset = 1'b0; rob_head = '0; r0 = '0; r1 = '0;
    step(); step();
    check("rst_strobes", 64'(strobes), 64'h0);
    check("rst_ready", 64'(req_ready), 64'h1);
    check("rst_state", 64'(dbg_state), 64'h0);
    check("rst_pc", 64'(ex_pc), 64'h0);
    reset = 1'b1;
    step();

    // T2 and table: single training requests issue one cycle later
    for (int i = 0; i < 6; i++) begin
      req_t t = '0;
      t.valid = 1'b1; t.tag = 5'd1; t.taken = vecs[i].taken; t.br = vecs[i].br;
      t.ret = vecs[i].ret; t.call = vecs[i].call; t.pc = vecs[i].pc;
      t.tgt = vecs[i].tgt; t.ra = vecs[i].ra;
      if (vecs[i].port) r1 = t; else r0 = t;
      step();
      r0 = '0; r1 = '0;
      check($sformatf("vec%0d_strobes", i), 64'(strobes), 64'(vecs[i].exp_str));
      check($sformatf("vec%0d_pc", i), 64'(ex_pc), 64'(vecs[i].pc));
      check($sformatf("vec%0d_tgt", i), 64'(actual_target_address), 64'(vecs[i].tgt));
      check($sformatf("vec%0d_ra", i), 64'(actual_return_address), 64'(vecs[i].ra));
      check($sformatf("vec%0d_br", i), 64'(ex_is_branch), 64'(vecs[i].br));
      check($sformatf("vec%0d_ret", i), 64'(ex_is_ret), 64'(vecs[i].ret));
      check($sformatf("vec%0d_taken", i), 64'(actual_taken), 64'(vecs[i].taken));
      step();
      check($sformatf("vec%0d_idle_strobes", i), 64'(strobes), 64'h0);
      check($sformatf("vec%0d_idle_state", i), 64'(dbg_state), 64'h0);
    end

    // T3: two branches in one cycle issue on consecutive cycles, port 0 first
    r0 = mk_train(5'd3, 32'h300); r0.br = 1'b1;
    r1 = mk_train(5'd4, 32'h400); r1.br = 1'b1;
    exp_q.push_back(32'h300); exp_q.push_back(32'h400);
    for (int c = 0; c < 2; c++) begin
      step();
      r0 = '0; r1 = '0;
      check($sformatf("t3_pc%0d", c), 64'(ex_pc), 64'(exp_q.pop_front()));
      check($sformatf("t3_pht%0d", c), 64'(update_pht), 64'h1);
      check($sformatf("t3_state%0d", c), 64'(dbg_state), 64'h1);
    end
    step();
    check("t3_idle_state", 64'(dbg_state), 64'h0);

    // T4: back-to-back pairs; req_ready drops once 3 entries wait, the next pair is ignored
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        r0 = mk_train(5'(2*c + 1), 32'h1000 + 32'(c) * 32'h20);
        r1 = mk_train(5'(2*c + 2), 32'h1010 + 32'(c) * 32'h20);
        if (c < 3) begin
          exp_q.push_back(32'h1000 + 32'(c) * 32'h20);
          exp_q.push_back(32'h1010 + 32'(c) * 32'h20);
        end
      end else begin
        r0 = '0; r1 = '0;
      end
      step();
      if (c < 4) check($sformatf("t4_ready%0d", c), 64'(req_ready), (c == 2) ? 64'h0 : 64'h1);
      if (c < 6) begin
        check($sformatf("t4_pc%0d", c), 64'(ex_pc), 64'(exp_q.pop_front()));
        check($sformatf("t4_btb%0d", c), 64'(strobes), 64'b000010);
      end else begin
        check("t4_idle_strobes", 64'(strobes), 64'h0);
      end
    end
    r0 = '0; r1 = '0;
    check("t4_queue_drained", 64'(exp_q.size()), 64'h0);

    // T5: queue holds tags 4,6,7; mispredict tag5 squashes 6 and 7
    r0 = mk_train(5'd1, 32'h510); r1 = mk_train(5'd2, 32'h520);
    step();
    check("t5_pc1", 64'(ex_pc), 64'h510);
    r0 = mk_train(5'd3, 32'h530); r1 = mk_train(5'd4, 32'h540);
    step();
    check("t5_pc2", 64'(ex_pc), 64'h520);
    r0 = mk_train(5'd6, 32'h560); r1 = mk_train(5'd7, 32'h570);
    step();
    check("t5_pc3", 64'(ex_pc), 64'h530);
    check("t5_ready_low", 64'(req_ready), 64'h0);
    r0 = mk_mp(5'd5, 32'h550, 1'b1, 1'b0, 1'b0, 9'h155, 3'd4); r1 = '0;
    step();
    r0 = '0;
    check("t5_rec_strobes", 64'(strobes), 64'b111110);
    check("t5_rec_ghr", 64'(ghr_snap), 64'h155);
    check("t5_rec_sp", 64'(rb_sp_snap), 64'h4);
    check("t5_rec_pc", 64'(ex_pc), 64'h550);
    check("t5_rec_ras", rb_ras_snap, {32'h550, ~32'h550});
    check("t5_rec_state", 64'(dbg_state), 64'h2);
    check("t5_ready_back", 64'(req_ready), 64'h1);
    step();
    check("t5_bub_strobes", 64'(strobes), 64'h0);
    check("t5_bub_pc", 64'(ex_pc), 64'h0);
    check("t5_bub_state", 64'(dbg_state), 64'h3);
    step();
    check("t5_pop_pc", 64'(ex_pc), 64'h540);
    check("t5_pop_strobes", 64'(strobes), 64'b000010);
    step();
    check("t5_after_strobes", 64'(strobes), 64'h0);
    check("t5_after_state", 64'(dbg_state), 64'h0);

    // T6: both ports mispredict; the older (tag8, port 1) wins
    rob_head = 5'd8;
    r0 = mk_mp(5'd9, 32'h900, 1'b1, 1'b0, 1'b0, 9'h0aa, 3'd1);
    r1 = mk_mp(5'd8, 32'h800, 1'b0, 1'b1, 1'b0, 9'h1ff, 3'd3);
    step();
    r0 = '0; r1 = '0; rob_head = '0;
    check("t6_pc", 64'(ex_pc), 64'h800);
    check("t6_ghr", 64'(ghr_snap), 64'h1ff);
    check("t6_sp", 64'(rb_sp_snap), 64'h3);
    check("t6_strobes", 64'(strobes), 64'b111011);
    step();
    check("t6_bub_state", 64'(dbg_state), 64'h3);
    step();
    check("t6_idle_strobes", 64'(strobes), 64'h0);

    // T7: older training beside a mispredict is kept, a second mispredict restarts recovery
    r0 = mk_mp(5'd5, 32'h250, 1'b1, 1'b0, 1'b0, 9'h011, 3'd2);
    r1 = mk_train(5'd3, 32'h130);
    step();
    check("t7_rec1_pc", 64'(ex_pc), 64'h250);
    r0 = mk_train(5'd6, 32'h160);
    r1 = mk_mp(5'd4, 32'h240, 1'b0, 1'b0, 1'b1, 9'h022, 3'd5);
    step();
    r0 = '0; r1 = '0;
    check("t7_rec2_pc", 64'(ex_pc), 64'h240);
    check("t7_rec2_strobes", 64'(strobes), 64'b111011);
    check("t7_rec2_state", 64'(dbg_state), 64'h2);
    step();
    check("t7_bub_strobes", 64'(strobes), 64'h0);
    step();
    check("t7_pop_pc", 64'(ex_pc), 64'h130);
    check("t7_pop_strobes", 64'(strobes), 64'b000010);
    step();
    check("t7_idle_strobes", 64'(strobes), 64'h0);

    // T8: reset mid-operation drops the queued entry
    r0 = mk_train(5'd1, 32'h700); r1 = mk_train(5'd2, 32'h710);
    step();
    check("t8_pc", 64'(ex_pc), 64'h700);
    r0 = '0; r1 = '0; reset = 1'b0;
    step();
    check("t8_rst_strobes", 64'(strobes), 64'h0);
    check("t8_rst_ready", 64'(req_ready), 64'h1);
    reset = 1'b1;
    step();
    check("t8_post_strobes", 64'(strobes), 64'h0);
    check("t8_post_pc", 64'(ex_pc), 64'h0);
    check("t8_post_state", 64'(dbg_state), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
